// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use bubbles, EX branch
// redirect, EX operand forwarding, memory-wait freeze and stall/flush counters.
//
// state     | meaning
// S_IDLE    | no bubble in progress; load-use checked every cycle
// S_LU_WAIT | extra load-use bubble cycles remain (r_cnt down to 0)
module hazard_ctrl_unit #(
    parameter int WIDTH     = 32,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     instruction_d,
    input  logic [WIDTH-1:0]     instruction_ex,
    input  logic [WIDTH-1:0]     instruction_mem,
    input  logic [WIDTH-1:0]     instruction_wb,
    input  logic                 Br_eq,
    input  logic                 Br_lt,
    input  logic                 mem_busy,
    output logic                 PC_sel_ex,
    output logic                 Br_Un_ex,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 freeze,
    output logic                 flush_d,
    output logic                 flush_ex,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [1:0] LU_RELOAD = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    typedef enum logic {S_IDLE, S_LU_WAIT} state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_cnt, w_cnt_nxt;
    logic [CNT_WIDTH-1:0]  r_stall_cnt, r_flush_cnt;

    logic [6:0] w_op_d, w_op_ex, w_op_mem, w_op_wb;
    logic [4:0] w_rs1_d, w_rs2_d, w_rs1_ex, w_rs2_ex, w_rd_ex, w_rd_mem, w_rd_wb;
    logic [2:0] w_f3_ex;
    logic       w_uses_rs2_d, w_lu_hit, w_taken, w_mem_fwd_ok, w_wb_fwd_ok;
    logic       w_unused_bits;

    function automatic logic f_writes_rd(input logic [6:0] op, input logic [4:0] rd);
        return (rd != 5'd0) && (op == OP_R || op == OP_I || op == OP_LOAD || op == OP_LUI ||
                                op == OP_AUIPC || op == OP_JAL || op == OP_JALR);
    endfunction

    assign w_op_d   = instruction_d[6:0];
    assign w_rs1_d  = instruction_d[19:15];
    assign w_rs2_d  = instruction_d[24:20];
    assign w_op_ex  = instruction_ex[6:0];
    assign w_rd_ex  = instruction_ex[11:7];
    assign w_f3_ex  = instruction_ex[14:12];
    assign w_rs1_ex = instruction_ex[19:15];
    assign w_rs2_ex = instruction_ex[24:20];
    assign w_op_mem = instruction_mem[6:0];
    assign w_rd_mem = instruction_mem[11:7];
    assign w_op_wb  = instruction_wb[6:0];
    assign w_rd_wb  = instruction_wb[11:7];
    assign w_unused_bits = ^{instruction_d[WIDTH-1:25], instruction_d[14:7],
                             instruction_ex[WIDTH-1:25], instruction_mem[WIDTH-1:12],
                             instruction_wb[WIDTH-1:12]};

    assign w_uses_rs2_d = (w_op_d == OP_R) || (w_op_d == OP_STORE) || (w_op_d == OP_BRANCH);
    assign w_lu_hit = (w_op_ex == OP_LOAD) && (w_rd_ex != 5'd0) &&
                      ((w_rd_ex == w_rs1_d) || (w_uses_rs2_d && (w_rd_ex == w_rs2_d)));

    always_comb begin
        w_taken  = 1'b0;
        Br_Un_ex = 1'b0;
        case (w_op_ex)
            OP_BRANCH: begin
                Br_Un_ex = (w_f3_ex[2:1] == 2'b11);
                case (w_f3_ex)
                    3'b000:         w_taken = Br_eq;
                    3'b001:         w_taken = !Br_eq;
                    3'b100, 3'b110: w_taken = Br_lt;
                    3'b101, 3'b111: w_taken = !Br_lt;
                    default:        w_taken = 1'b0;
                endcase
            end
            OP_JAL, OP_JALR: w_taken = 1'b1;
            default:         w_taken = 1'b0;
        endcase
    end

    assign PC_sel_ex = w_taken && !mem_busy && !rst;
    assign freeze    = mem_busy;

    // Loads in MEM have no result yet, so only WB may supply a load value.
    assign w_mem_fwd_ok = f_writes_rd(w_op_mem, w_rd_mem) && (w_op_mem != OP_LOAD);
    assign w_wb_fwd_ok  = f_writes_rd(w_op_wb, w_rd_wb);

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (w_mem_fwd_ok && w_rd_mem == w_rs1_ex)     fwd_a = 2'b01;
        else if (w_wb_fwd_ok && w_rd_wb == w_rs1_ex)  fwd_a = 2'b10;
        if (w_mem_fwd_ok && w_rd_mem == w_rs2_ex)     fwd_b = 2'b01;
        else if (w_wb_fwd_ok && w_rd_wb == w_rs2_ex)  fwd_b = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (mem_busy) begin
            w_state_nxt = r_state;
        end else if (PC_sel_ex) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_lu_hit && LOAD_LAT > 1) begin
                        w_state_nxt = S_LU_WAIT;
                        w_cnt_nxt   = LU_RELOAD;
                    end
                end
                S_LU_WAIT: begin
                    if (r_cnt == 2'd0) w_state_nxt = S_IDLE;
                    else               w_cnt_nxt   = r_cnt - 2'd1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        flush_ex = 1'b0;
        if (!rst && !mem_busy) begin
            if (PC_sel_ex) begin
                flush_d  = 1'b1;
                flush_ex = 1'b1;
            end else if (r_state == S_LU_WAIT || w_lu_hit) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_d && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            if (flush_d && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (LOAD_LAT=3/16-bit counters and
// LOAD_LAT=1/2-bit counters) share stimulus and are compared with a reference model.
module tb_hazard_ctrl_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, br_eq, br_lt, busy;
    logic [31:0] ins_d, ins_ex, ins_mem, ins_wb;
    logic [1:0]  pc_sel, br_un, stall_f, stall_d, frz, flush_d, flush_ex;
    logic [1:0]  fwd_a [2];
    logic [1:0]  fwd_b [2];
    logic [15:0] scnt_a, fcnt_a;
    logic [1:0]  scnt_b, fcnt_b;

    int n_vec = 0;
    int n_err = 0;
    int rem  [2] = '{0, 0};
    int scnt [2] = '{0, 0};
    int fcnt [2] = '{0, 0};
    int lat  [2] = '{3, 1};
    int cmax [2] = '{65535, 3};

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.WIDTH(32), .LOAD_LAT(3), .CNT_WIDTH(16)) u_a (
        .clk(clk), .rst(rst), .instruction_d(ins_d), .instruction_ex(ins_ex),
        .instruction_mem(ins_mem), .instruction_wb(ins_wb), .Br_eq(br_eq), .Br_lt(br_lt),
        .mem_busy(busy), .PC_sel_ex(pc_sel[0]), .Br_Un_ex(br_un[0]), .stall_f(stall_f[0]),
        .stall_d(stall_d[0]), .freeze(frz[0]), .flush_d(flush_d[0]), .flush_ex(flush_ex[0]),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

    hazard_ctrl_unit #(.WIDTH(32), .LOAD_LAT(1), .CNT_WIDTH(2)) u_b (
        .clk(clk), .rst(rst), .instruction_d(ins_d), .instruction_ex(ins_ex),
        .instruction_mem(ins_mem), .instruction_wb(ins_wb), .Br_eq(br_eq), .Br_lt(br_lt),
        .mem_busy(busy), .PC_sel_ex(pc_sel[1]), .Br_Un_ex(br_un[1]), .stall_f(stall_f[1]),
        .stall_d(stall_d[1]), .freeze(frz[1]), .flush_d(flush_d[1]), .flush_ex(flush_ex[1]),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3);
        return {7'd0, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic m_writes(input logic [31:0] ins);
        return (ins[11:7] != 0) && (ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6f, 7'h67});
    endfunction

    function automatic logic m_taken(input logic [31:0] ins, input logic eq, input logic lt);
        logic [2:0] f3;
        f3 = ins[14:12];
        if (ins[6:0] == 7'h6f || ins[6:0] == 7'h67) return 1'b1;
        if (ins[6:0] != 7'h63 || f3 == 3'd2 || f3 == 3'd3) return 1'b0;
        return (f3[2] ? lt : eq) ^ f3[0];
    endfunction

    function automatic logic m_brun(input logic [31:0] ins);
        return (ins[6:0] == 7'h63) && (ins[14:12] >= 3'd6);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic [31:0] mem,
                                         input logic [31:0] wb);
        if (m_writes(mem) && mem[6:0] != 7'h03 && mem[11:7] == rs) return 2'd1;
        if (m_writes(wb) && wb[11:7] == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic m_lu(input logic [31:0] ex, input logic [31:0] d);
        logic use2;
        use2 = d[6:0] inside {7'h33, 7'h23, 7'h63};
        return ex[6:0] == 7'h03 && ex[11:7] != 0 &&
               (ex[11:7] == d[19:15] || (use2 && ex[11:7] == d[24:20]));
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] d, input logic [31:0] ex, input logic [31:0] mem,
                          input logic [31:0] wb, input logic eq, input logic lt,
                          input logic b, input logic r);
        ins_d = d; ins_ex = ex; ins_mem = mem; ins_wb = wb;
        br_eq = eq; br_lt = lt; busy = b; rst = r;
    endtask

    // Checks one cycle's outputs at mid-cycle, then advances the model across the edge.
    task automatic cyc();
        logic pc, lu, st [2], fd;
        #4;
        pc = m_taken(ins_ex, br_eq, br_lt) && !busy && !rst;
        lu = m_lu(ins_ex, ins_d);
        fd = pc;
        for (int k = 0; k < 2; k++) begin
            st[k] = !rst && !busy && !pc && (rem[k] > 0 || lu);
            chk("pc_sel",   k, 32'(pc_sel[k]),   32'(pc));
            chk("br_un",    k, 32'(br_un[k]),    32'(m_brun(ins_ex)));
            chk("stall_f",  k, 32'(stall_f[k]),  32'(st[k]));
            chk("stall_d",  k, 32'(stall_d[k]),  32'(st[k]));
            chk("freeze",   k, 32'(frz[k]),      32'(busy));
            chk("flush_d",  k, 32'(flush_d[k]),  32'(fd));
            chk("flush_ex", k, 32'(flush_ex[k]), 32'(fd || st[k]));
            chk("fwd_a",    k, 32'(fwd_a[k]),    32'(m_fwd(ins_ex[19:15], ins_mem, ins_wb)));
            chk("fwd_b",    k, 32'(fwd_b[k]),    32'(m_fwd(ins_ex[24:20], ins_mem, ins_wb)));
            chk("stall_cnt", k, (k == 0) ? 32'(scnt_a) : 32'(scnt_b), 32'(scnt[k]));
            chk("flush_cnt", k, (k == 0) ? 32'(fcnt_a) : 32'(fcnt_b), 32'(fcnt[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                rem[k] = 0; scnt[k] = 0; fcnt[k] = 0;
            end else begin
                if (st[k] && scnt[k] < cmax[k]) scnt[k]++;
                if (fd && fcnt[k] < cmax[k]) fcnt[k]++;
                if (busy)             rem[k] = rem[k];
                else if (pc)          rem[k] = 0;
                else if (rem[k] > 0)  rem[k]--;
                else if (lu)          rem[k] = lat[k] - 1;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] lw5, add_use, sw_use, addi_r5, beq;
        logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                                  7'h17, 7'h6f, 7'h67, 7'h7f, 7'h03};
        lw5     = enc(7'h03, 5'd5, 5'd2, 5'd0, 3'd2);
        add_use = enc(7'h33, 5'd6, 5'd5, 5'd1, 3'd0);
        sw_use  = enc(7'h23, 5'd0, 5'd2, 5'd5, 3'd2);
        addi_r5 = enc(7'h13, 5'd6, 5'd1, 5'd5, 3'd0);
        beq     = enc(7'h63, 5'd0, 5'd1, 5'd2, 3'd0);

        set_in(NOP, NOP, NOP, NOP, 0, 0, 0, 1);
        @(posedge clk); #1;
        // Reset held with a load-use pair present: no stall may appear.
        set_in(add_use, lw5, NOP, NOP, 0, 0, 0, 1);
        cyc(); cyc();

        // Load-use: bubble of 1 (dut1) / 3 (dut0) cycles; load leaves EX after detection.
        set_in(add_use, lw5, NOP, NOP, 0, 0, 0, 0); cyc();
        set_in(add_use, NOP, NOP, NOP, 0, 0, 0, 0);
        repeat (3) cyc();
        set_in(sw_use, lw5, NOP, NOP, 0, 0, 0, 0); cyc();
        set_in(sw_use, NOP, NOP, NOP, 0, 0, 0, 0);
        repeat (3) cyc();
        set_in(addi_r5, lw5, NOP, NOP, 0, 0, 0, 0); cyc();

        // Branch matrix, then JAL / JALR.
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 4; c++) begin
                set_in(NOP, enc(7'h63, 5'd0, 5'd1, 5'd2, 3'(f)), NOP, NOP, c[1], c[0], 0, 0);
                cyc();
            end
        set_in(NOP, enc(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0), NOP, NOP, 0, 0, 0, 0); cyc();
        set_in(NOP, enc(7'h67, 5'd1, 5'd4, 5'd0, 3'd0), NOP, NOP, 0, 0, 0, 0); cyc();

        // Forwarding priority and special cases.
        set_in(NOP, enc(7'h33, 5'd7, 5'd3, 5'd3, 3'd0), enc(7'h33, 5'd3, 5'd1, 5'd2, 3'd0),
               enc(7'h33, 5'd3, 5'd1, 5'd2, 3'd0), 0, 0, 0, 0); cyc();
        set_in(NOP, enc(7'h33, 5'd7, 5'd3, 5'd3, 3'd0), enc(7'h03, 5'd3, 5'd1, 5'd0, 3'd2),
               enc(7'h33, 5'd3, 5'd1, 5'd2, 3'd0), 0, 0, 0, 0); cyc();
        set_in(NOP, enc(7'h33, 5'd7, 5'd0, 5'd0, 3'd0), enc(7'h33, 5'd0, 5'd1, 5'd2, 3'd0),
               enc(7'h33, 5'd0, 5'd1, 5'd2, 3'd0), 0, 0, 0, 0); cyc();

        // Memory wait arriving in the second bubble cycle; then a branch under freeze.
        set_in(add_use, lw5, NOP, NOP, 0, 0, 0, 0); cyc();
        set_in(add_use, NOP, NOP, NOP, 0, 0, 1, 0);
        repeat (4) cyc();
        set_in(add_use, NOP, NOP, NOP, 0, 0, 0, 0);
        repeat (3) cyc();
        set_in(NOP, beq, NOP, NOP, 1, 0, 1, 0);
        repeat (2) cyc();
        set_in(NOP, beq, NOP, NOP, 1, 0, 0, 0); cyc();

        // Saturation with a persistent load-use pair, then reset mid-stall.
        set_in(add_use, lw5, NOP, NOP, 0, 0, 0, 1); cyc();
        set_in(add_use, lw5, NOP, NOP, 0, 0, 0, 0);
        repeat (5) cyc();
        set_in(add_use, lw5, NOP, NOP, 0, 0, 0, 1); cyc();
        set_in(add_use, NOP, NOP, NOP, 0, 0, 0, 0);
        repeat (2) cyc();

        // Randomised traffic over a small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r [4];
            for (int j = 0; j < 4; j++)
                r[j] = enc(ops[$urandom_range(10)], 5'($urandom_range(3)), 5'($urandom_range(3)),
                           5'($urandom_range(3)), 3'($urandom_range(7)));
            set_in(r[0], r[1], r[2], r[3], 1'($urandom_range(1)), 1'($urandom_range(1)),
                   ($urandom_range(99) < 20), ($urandom_range(99) < 3));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
